// File: rtl/alu.sv
// 64-bit execute-stage ALU with a registered NZCV condition-flag register.
// Optional shifter (LSL/LSR) is built only when ALU_SHIFT_EN is defined.
module alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    input  logic             flag_we,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_LSR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_PASS = 4'b0111
    } op_e;

    op_e              op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             n_flag;
    logic             c_flag;
    logic             v_flag;

    assign op     = op_e'(ALUControl);
    assign is_sub = (op == OP_SUB);

    // ADD and SUB share one adder; SUB is a + ~b + 1 so the carry-out is the
    // "no borrow" indication.
    assign b_eff = is_sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    // NOTE: combinational logic assigns defaults first so no path leaves an
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_PASS: result = b;
            OP_ADD: begin
                result = sum[MSB:0];
                c_flag = sum[WIDTH];
                v_flag = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = sum[MSB:0];
                c_flag = sum[WIDTH];
                v_flag = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
`ifdef ALU_SHIFT_EN
            OP_LSL:  result = a << b[SHW-1:0];
            OP_LSR:  result = a >> b[SHW-1:0];
`endif
            default: result = '0;
        endcase
    end

    assign zero   = (result == '0);
    assign n_flag = result[MSB];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags <= {n_flag, zero, c_flag, v_flag};
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu: combinational result/zero per vector,
// NZCV captured through the flag register, plus reset/hold sequences.
module tb_alu;

    localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  alu_control;
    logic        flag_we;
    logic [63:0] result;
    logic        zero;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_result;
        logic        exp_zero;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUControl (alu_control),
        .flag_we    (flag_we),
        .result     (result),
        .zero       (zero),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] ctrl, input logic [63:0] va, input logic [63:0] vb,
                           input logic [63:0] er, input logic ez, input logic [3:0] ef);
        vec_t v;
        v.ctrl = ctrl; v.a = va; v.b = vb;
        v.exp_result = er; v.exp_zero = ez; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ctrl, a, b, result, zero, {N,Z,C,V}
        add_vec(4'b0000, 64'd2, 64'd2, 64'd2, 1'b0, 4'b0000);
        add_vec(4'b0000, 64'd2, M2,    64'd2, 1'b0, 4'b0000);
        add_vec(4'b0001, 64'd2, M2,    M2,    1'b0, 4'b1000);
        add_vec(4'b0011, 64'd5, 64'd3, 64'd6, 1'b0, 4'b0000);
        add_vec(4'b0010, M2,    M2,    64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'b1010);
        add_vec(4'b0010, 64'd2, M2,    64'd0, 1'b1, 4'b0110);
        add_vec(4'b0010, MAXP,  MAXP,  M2,    1'b0, 4'b1001);
        add_vec(4'b0110, 64'd2, 64'd2, 64'd0, 1'b1, 4'b0110);
        add_vec(4'b0110, M2,    M2,    64'd0, 1'b1, 4'b0110);
        add_vec(4'b0110, 64'd2, M2,    64'd4, 1'b0, 4'b0000);
        add_vec(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b1000);
        add_vec(4'b0110, MINN,  64'd1, MAXP,  1'b0, 4'b0011);
        add_vec(4'b0111, 64'd9, 64'd2, 64'd2, 1'b0, 4'b0000);
        add_vec(4'b0111, 64'd9, M2,    M2,    1'b0, 4'b1000);
        add_vec(4'b1111, 64'd7, 64'd3, 64'd0, 1'b1, 4'b0100);
        add_vec(4'b1000, M2,    M2,    64'd0, 1'b1, 4'b0100);
`ifdef ALU_SHIFT_EN
        add_vec(4'b0100, 64'd1, 64'd63, MINN,  1'b0, 4'b1000);
        add_vec(4'b0101, MINN,  64'd63, 64'd1, 1'b0, 4'b0000);
        add_vec(4'b0100, 64'd5, 64'd64, 64'd5, 1'b0, 4'b0000);
        add_vec(4'b0101, 64'd5, 64'd0,  64'd5, 1'b0, 4'b0000);
`else
        add_vec(4'b0100, 64'd1, 64'd63, 64'd0, 1'b1, 4'b0100);
        add_vec(4'b0101, MINN,  64'd63, 64'd0, 1'b1, 4'b0100);
`endif

        a = '0; b = '0; alu_control = '0; flag_we = 1'b0; reset = 1'b1;
        tick();
        check("reset flags", {60'd0, flags}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            a = vecs[i].a; b = vecs[i].b; alu_control = vecs[i].ctrl;
            #1;
            check($sformatf("v%0d result", i), result, vecs[i].exp_result);
            check($sformatf("v%0d zero", i), {63'd0, zero}, {63'd0, vecs[i].exp_zero});
            flag_we = 1'b1;
            tick();
            flag_we = 1'b0;
            check($sformatf("v%0d flags", i), {60'd0, flags}, {60'd0, vecs[i].exp_flags});
        end

        // Reset clears flags and leaves the combinational path alone.
        alu_control = 4'b0001; a = 64'd2; b = M2; reset = 1'b1;
        #1;
        check("result during reset", result, M2);
        tick();
        check("flags after reset", {60'd0, flags}, 64'd0);
        reset = 1'b0;

        // SUB 2-2 captured, then held while inputs change with flag_we low.
        alu_control = 4'b0110; a = 64'd2; b = 64'd2; flag_we = 1'b1;
        tick();
        check("flags sub 2-2", {60'd0, flags}, 64'd6);
        flag_we = 1'b0; alu_control = 4'b0010; a = MAXP; b = MAXP;
        tick();
        tick();
        check("flags hold", {60'd0, flags}, 64'd6);

        // Reset wins over flag_we.
        alu_control = 4'b0001; a = 64'd2; b = M2; flag_we = 1'b1; reset = 1'b1;
        tick();
        check("reset beats flag_we", {60'd0, flags}, 64'd0);
        reset = 1'b0;
        tick();
        check("capture after reset", {60'd0, flags}, 64'd8);
        flag_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 64-bit integer ALU for the ARM64 pipeline processor's execute stage.
- Combinationally computes `result` and `zero` from operands `a`/`b` under a 4-bit `ALUControl` code.
- Also holds an NZCV condition-flag register, updated on the clock when `flag_we` is asserted, for conditional branches.

Parameters:
- WIDTH, 64, operand/result width in bits; all behaviour below is stated for 64.

Ports:
- clk  input  1  system clock; flag register updates on rising edge
- reset  input  1  synchronous, active-high reset
- a  input  64  operand A
- b  input  64  operand B
- ALUControl  input  4  operation select
- flag_we  input  1  when high, capture NZCV of the current operation at the next rising clk
- result  output  64  operation result (combinational)
- zero  output  1  high when result == 0 (combinational)
- flags  output  4  registered {N,Z,C,V}

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- result/zero are purely combinational: zero-cycle latency, independent of clk and reset.
- Operation codes:
  - 4'b0000: AND, a & b
  - 4'b0001: OR, a | b
  - 4'b0010: ADD, a + b, modulo 2^64; carry-out dropped from result
  - 4'b0011: XOR, a ^ b
  - 4'b0110: SUB, a - b, computed as a + ~b + 1, modulo 2^64
  - 4'b0111: PASS B, result = b
  - 4'b0100: LSL, a << b[5:0] (only with ALU_SHIFT_EN)
  - 4'b0101: LSR, a >> b[5:0] logical (only with ALU_SHIFT_EN)
  - All other codes: result = 64'h0, so zero = 1
- zero = (result == 64'h0) for every code.
- Combinational flag values:
  - N = result[63]; Z = zero.
  - ADD: C = carry out of bit 63; V = (a[63]==b[63]) && (result[63]!=a[63]).
  - SUB: C = carry out of a + ~b + 1, i.e. 1 when no borrow (a >= b unsigned); V = (a[63]!=b[63]) && (result[63]!=a[63]).
  - All other ops: C = 0, V = 0.
- flags register:
  - On rising clk, reset=1 forces flags = 4'b0000, regardless of flag_we.
  - Else, if flag_we=1, flags <= {N,Z,C,V} of the current inputs.
  - Else flags holds its value.
- reset has no effect on result/zero.
- Overflow wraps silently; no saturation and no exceptions.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: codes 0100 (LSL) and 0101 (LSR) are implemented as above; shift amount is b[5:0], and shifts of 0 pass a unchanged.
- Undefined: 0100 and 0101 fall into the unlisted-code case (result 0, zero 1, C=V=0); no shifter logic is synthesised.

Test Plan:
- Logic ops:
  - a=2, b=2, AND -> result 2, zero 0.
  - a=2, b=-2, AND -> result 2, zero 0.
  - a=2, b=-2, OR -> result 64'hFFFF_FFFF_FFFF_FFFE, zero 0.
- ADD:
  - a=-2, b=-2 -> result -4, zero 0.
  - a=2, b=-2 -> result 0, zero 1, C=1.
  - a=b=64'h7FFF_FFFF_FFFF_FFFF -> result 64'hFFFF_FFFF_FFFF_FFFE, zero 0, V=1, N=1.
- SUB:
  - a=2, b=2 -> result 0, zero 1, C=1.
  - a=-2, b=-2 -> result 0, zero 1.
  - a=2, b=-2 -> result 4, zero 0.
- PASS B / unlisted: code 0111 with b in {2, -2} -> result == b, zero 0; code 1111 -> result 0, zero 1.
- Flags:
  - reset=1 for one cycle -> flags 0000.
  - SUB 2-2 with flag_we=1, one clk -> flags 4'b0110.
  - Then flag_we=0 with changed inputs -> flags unchanged.
  - Asserting reset together with flag_we=1 -> flags 0000.
- ALU_SHIFT_EN: a=1, b=63, LSL -> 64'h8000_0000_0000_0000. a=64'h8000_0000_0000_0000, b=63, LSR -> 1. Without the macro, LSL -> result 0, zero 1.
